// File: rtl/word_segment_reader.sv
// word_segment_reader: reads a {start,end} span from a circular sample RAM and streams it on valid/ready with olast.
// Latency: descriptor sampled at edge T, oseg_ack during T+1 (first read), first ovalid at T+3; 1 sample/cycle at iready=1.
// Backpressure: reads stall so FIFO occupancy plus RAM read in flight never exceeds 2; iready=0 never drops or overflows.
// Optional build macro WORD_READER_PAD_EN: zero-pad every segment to exactly MAX_LEN samples.

// Small generic FIFO; DEPTH must be a power of two, push only when not full, pop ignored when empty.
module wsr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ipush,
  input  logic [W-1:0]             ipush_dat,
  input  logic                     ipop,
  output logic                     opop_vld,
  output logic [W-1:0]             opop_dat,
  output logic [$clog2(DEPTH):0]   ocount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign opop_vld = (ocount != '0);
  assign opop_dat = mem[rd_ptr];
  assign do_pop   = ipop && opop_vld;

  // Pointer and occupancy bookkeeping; reset flushes the contents.
  always_ff @(posedge iclk) begin
    if (irst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocount <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(ipush);
      rd_ptr <= rd_ptr + AW'(do_pop);
      ocount <= ocount + CW'(ipush) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge iclk) begin
    if (ipush) mem[wr_ptr] <= ipush_dat;
  end
endmodule

module word_segment_reader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 8000
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iseg_valid,
  input  logic [31:0]       istart_idx,
  input  logic [31:0]       iend_idx,
  output logic              oseg_ack,
  output logic              omem_rd_en,
  output logic [ADDR_W-1:0] omem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ovalid,
  input  logic              iready,
  output logic [DATA_W-1:0] odata,
  output logic              olast,
  output logic              otrunc,
  output logic              obusy
);
  // One extra bit so a full-buffer span (2**ADDR_W) is representable.
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ACK, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] diff;
  logic [CNT_W-1:0]  span;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue;
  logic              issue_last;
  logic              room;
  logic              pop;
  logic              pad_phase;
  logic              inflight_vld;
  logic              inflight_last;
  logic [DATA_W:0]   push_dat;
  logic [DATA_W:0]   fifo_dat;
  logic              fifo_vld;
  logic [1:0]        fifo_cnt;
  logic              unused_hi;

  // Indices are circular: only the low ADDR_W bits matter.
  assign unused_hi = ^{istart_idx[31:ADDR_W], iend_idx[31:ADDR_W]};
  assign diff      = iend_idx[ADDR_W-1:0] - istart_idx[ADDR_W-1:0];
  assign span      = {1'b0, diff} + CNT_W'(1);

`ifdef WORD_READER_PAD_EN
  logic inflight_pad;
  // Every frame is MAX_LEN long; issues past len become zero samples with no RAM access.
  assign total     = MAX_LEN_C;
  assign pad_phase = (issue_cnt >= len);
  assign push_dat  = {inflight_last, inflight_pad ? {DATA_W{1'b0}} : imem_rdata};

  // Remember whether the issue in flight was a padding slot.
  always_ff @(posedge iclk) begin
    if (irst) inflight_pad <= 1'b0;
    else      inflight_pad <= pad_phase;
  end
`else
  assign total     = len;
  assign pad_phase = 1'b0;
  assign push_dat  = {inflight_last, imem_rdata};
`endif

  assign pop        = ovalid && iready;
  assign issue_last = (issue_cnt == total - CNT_W'(1));
  // Room if what is buffered plus in flight, less what leaves this cycle, is below two.
  assign room       = (3'(fifo_cnt) + 3'(inflight_vld)) < (3'd2 + 3'(pop));
  assign omem_addr  = rd_addr;

  wsr_fifo #(.W(DATA_W + 1), .DEPTH(2)) u_out_fifo (
    .iclk      (iclk),
    .irst      (irst),
    .ipush     (inflight_vld),
    .ipush_dat (push_dat),
    .ipop      (pop),
    .opop_vld  (fifo_vld),
    .opop_dat  (fifo_dat),
    .ocount    (fifo_cnt)
  );

  // Output stream, forced to zero when nothing is buffered.
  assign ovalid = fifo_vld;
  assign odata  = fifo_vld ? fifo_dat[DATA_W-1:0] : '0;
  assign olast  = fifo_vld && fifo_dat[DATA_W];

  // State register.
  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, ack/busy and read-issue decode.
  always_comb begin
    state_nxt  = state;
    oseg_ack   = 1'b0;
    obusy      = 1'b0;
    issue      = 1'b0;
    omem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (iseg_valid) state_nxt = ACK;
      end
      ACK: begin
        oseg_ack = 1'b1;
        obusy    = 1'b1;
        issue    = room;
        if (issue && issue_last) state_nxt = DRAIN;
        else                     state_nxt = READ;
      end
      READ: begin
        obusy = 1'b1;
        issue = room;
        if (issue && issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        obusy = 1'b1;
        if (pop && olast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    omem_rd_en = issue && !pad_phase;
  end

  // Descriptor latch, read address/count advance and in-flight tracking.
  always_ff @(posedge iclk) begin
    if (irst) begin
      rd_addr       <= '0;
      len           <= '0;
      issue_cnt     <= '0;
      otrunc        <= 1'b0;
      inflight_vld  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight_vld  <= issue;
      inflight_last <= issue_last;
      if (state == IDLE && iseg_valid) begin
        rd_addr   <= istart_idx[ADDR_W-1:0];
        len       <= (span > MAX_LEN_C) ? MAX_LEN_C : span;
        otrunc    <= (span > MAX_LEN_C);
        issue_cnt <= '0;
      end else if (issue) begin
        rd_addr   <= rd_addr + ADDR_W'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_word_segment_reader.sv
// tb_word_segment_reader: directed plus randomized segments against a span/length reference model.
// Latency: checks ack at the cycle after acceptance and the full output/read sequences per segment.
// Backpressure: iready is randomly toggled; stalled outputs must hold and at most two samples run ahead.
module tb_word_segment_reader;
  localparam int AW   = 7;
  localparam int DW   = 16;
  localparam int ML   = 100;
  localparam int NBUF = 128;

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic          iseg_valid = 1'b0;
  logic [31:0]   istart_idx = '0;
  logic [31:0]   iend_idx = '0;
  logic          oseg_ack;
  logic          omem_rd_en;
  logic [AW-1:0] omem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          ovalid;
  logic          iready = 1'b1;
  logic [DW-1:0] odata;
  logic          olast;
  logic          otrunc;
  logic          obusy;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;
  int rd_total = 0;
  int xfer_total = 0;
  int ack_cnt  = 0;

  logic [DW-1:0] ram [NBUF];
  logic [DW-1:0] obs_dat [$];
  logic          obs_last [$];
  logic [AW-1:0] obs_addr [$];

  word_segment_reader #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN(ML)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .iseg_valid (iseg_valid),
    .istart_idx (istart_idx),
    .iend_idx   (iend_idx),
    .oseg_ack   (oseg_ack),
    .omem_rd_en (omem_rd_en),
    .omem_addr  (omem_addr),
    .imem_rdata (imem_rdata),
    .ovalid     (ovalid),
    .iready     (iready),
    .odata      (odata),
    .olast      (olast),
    .otrunc     (otrunc),
    .obusy      (obusy)
  );

  initial forever #5 iclk = ~iclk;

  // Sample RAM with one-cycle read latency.
  always @(posedge iclk) begin
    if (omem_rd_en) imem_rdata <= ram[omem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always high, or randomly high two thirds of the time.
  initial forever begin
    @(posedge iclk);
    #1;
    iready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: record reads and transfers, check stall stability and read-ahead bound.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_dat;
    logic          prev_last;
    prev_stall = 1'b0;
    prev_dat   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge iclk);
      if (irst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_vld", 32'(ovalid), 1);
          chk("stall_dat", 32'(odata), 32'(prev_dat));
          chk("stall_last", 32'(olast), 32'(prev_last));
        end
        prev_stall = ovalid && !iready;
        prev_dat   = odata;
        prev_last  = olast;
        if (oseg_ack) ack_cnt++;
        if (omem_rd_en) begin
          obs_addr.push_back(omem_addr);
          rd_total++;
        end
        if (ovalid && iready) begin
          obs_dat.push_back(odata);
          obs_last.push_back(olast);
          xfer_total++;
        end
`ifndef WORD_READER_PAD_EN
        chk("ahead", 32'((rd_total - xfer_total) <= 2), 1);
`endif
      end
    end
  end

  task automatic clear_obs();
    obs_dat.delete();
    obs_last.delete();
    obs_addr.delete();
    rd_total   = 0;
    xfer_total = 0;
    ack_cnt    = 0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (obusy !== 1'b0 && cyc < 3000) begin
      @(negedge iclk);
      cyc++;
    end
    chk({tag, ".idle"}, 32'(obusy), 0);
  endtask

  task automatic run_seg(input string tag, input logic [31:0] s, input logic [31:0] e,
                         input int mode, input bit hold);
    logic [DW-1:0] exp_dat [$];
    logic          exp_last [$];
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   diff;
    logic [31:0]   a;
    int            span, len, total, reps;
    bit            trunc;

    diff  = e - s;
    span  = int'(diff % 32'(NBUF)) + 1;
    trunc = (span > ML);
    len   = trunc ? ML : span;
`ifdef WORD_READER_PAD_EN
    total = ML;
`else
    total = len;
`endif
    reps = hold ? 2 : 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < total; i++) begin
        a = (s + 32'(i)) % 32'(NBUF);
        exp_dat.push_back((i < len) ? ram[a] : '0);
        exp_last.push_back(i == total - 1);
        if (i < len) exp_addr.push_back(AW'(a));
      end
    end

    clear_obs();
    rdy_mode = mode;
    @(posedge iclk);
    #1;
    iseg_valid = 1'b1;
    istart_idx = s;
    iend_idx   = e;
    @(negedge iclk);
    chk({tag, ".ack_pre"}, 32'(oseg_ack), 0);
    @(negedge iclk);
    chk({tag, ".ack"}, 32'(oseg_ack), 1);
    chk({tag, ".busy"}, 32'(obusy), 1);
    chk({tag, ".rd_first"}, 32'(omem_rd_en), 1);
    chk({tag, ".addr_first"}, 32'(omem_addr), s % 32'(NBUF));
    if (!hold) begin
      @(posedge iclk);
      #1;
      iseg_valid = 1'b0;
      @(negedge iclk);
      chk({tag, ".ack_once"}, 32'(oseg_ack), 0);
    end
    wait_idle(tag);
    chk({tag, ".trunc"}, 32'(otrunc), 32'(trunc));
    if (hold) begin
      chk({tag, ".acks_busy"}, 32'(ack_cnt), 1);
      @(negedge iclk);
      chk({tag, ".ack_again"}, 32'(oseg_ack), 1);
      @(posedge iclk);
      #1;
      iseg_valid = 1'b0;
      wait_idle({tag, "2"});
    end
    chk({tag, ".acks"}, 32'(ack_cnt), 32'(reps));
    chk({tag, ".n_samples"}, 32'(obs_dat.size()), 32'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
      chk($sformatf("%s.dat[%0d]", tag, i), 32'(obs_dat[i]), 32'(exp_dat[i]));
      chk($sformatf("%s.last[%0d]", tag, i), 32'(obs_last[i]), 32'(exp_last[i]));
    end
    chk({tag, ".n_reads"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk($sformatf("%s.addr[%0d]", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NBUF; i++) ram[i] = DW'($urandom);

    irst = 1'b1;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("rst.ack", 32'(oseg_ack), 0);
    chk("rst.rd_en", 32'(omem_rd_en), 0);
    chk("rst.addr", 32'(omem_addr), 0);
    chk("rst.valid", 32'(ovalid), 0);
    chk("rst.data", 32'(odata), 0);
    chk("rst.last", 32'(olast), 0);
    chk("rst.trunc", 32'(otrunc), 0);
    chk("rst.busy", 32'(obusy), 0);
    @(posedge iclk);
    #1;
    irst = 1'b0;

    run_seg("basic", 32'd100, 32'd103, 0, 1'b0);
    run_seg("wrap", 32'hABCD_007E, 32'h1234_0081, 0, 1'b0);
    run_seg("trunc", 32'd0, 32'd119, 1, 1'b0);
    run_seg("stall64", 32'd10, 32'd73, 1, 1'b0);
    run_seg("hold", 32'd5, 32'd9, 1, 1'b1);

    // Reset in the middle of a truncated segment's read phase.
    clear_obs();
    rdy_mode = 1;
    @(posedge iclk);
    #1;
    iseg_valid = 1'b1;
    istart_idx = 32'd0;
    iend_idx   = 32'd119;
    @(posedge iclk);
    #1;
    iseg_valid = 1'b0;
    repeat (12) @(posedge iclk);
    @(negedge iclk);
    chk("midrst.busy_pre", 32'(obusy), 1);
    chk("midrst.trunc_pre", 32'(otrunc), 1);
    @(posedge iclk);
    #1;
    irst = 1'b1;
    @(posedge iclk);
    #1;
    irst = 1'b0;
    @(negedge iclk);
    chk("midrst.ack", 32'(oseg_ack), 0);
    chk("midrst.rd_en", 32'(omem_rd_en), 0);
    chk("midrst.addr", 32'(omem_addr), 0);
    chk("midrst.valid", 32'(ovalid), 0);
    chk("midrst.data", 32'(odata), 0);
    chk("midrst.last", 32'(olast), 0);
    chk("midrst.trunc", 32'(otrunc), 0);
    chk("midrst.busy", 32'(obusy), 0);

    run_seg("post_rst", 32'd60, 32'd70, 1, 1'b0);
    run_seg("one", 32'd50, 32'd50, 0, 1'b0);
    run_seg("full", 32'd20, 32'd19, 1, 1'b0);
    run_seg("exact", 32'd0, 32'd99, 0, 1'b0);
    run_seg("over1", 32'd0, 32'd100, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run_seg($sformatf("rand%0d", k), $urandom, $urandom, 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
